// File: rtl/adc_code_to_float.sv
// adc_code_to_float: ADC code -> IEEE-754 single, with sample-aligned gain/offset snapshots.
// Optional ADC_SIGNED_CODE_EN: treat the raw code as two's complement instead of offset binary.
module adc_code_to_float #(
    parameter int          ADC_BITS   = 24,
    parameter logic [31:0] GAIN_RST   = 32'h35a0_0000,
    parameter logic [31:0] OFFSET_RST = 32'hc120_0000
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_aresetn,
    input  logic [ADC_BITS-1:0] s_raw_axis_tdata,
    input  logic                s_raw_axis_tvalid,
    output logic                s_raw_axis_tready,
    input  logic [31:0]         i_gain_s_axis_tdata,
    input  logic                i_gain_s_axis_tvalid,
    input  logic [31:0]         i_offset_s_axis_tdata,
    input  logic                i_offset_s_axis_tvalid,
    output logic [31:0]         m_val_axis_tdata,
    output logic [31:0]         m_gain_axis_tdata,
    output logic [31:0]         m_offset_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [31:0]         o_sample_cnt
);

    logic                en;
    logic [31:0]         gain_shadow, offset_shadow;
    logic [31:0]         gain_snap, offset_snap;
    logic                in_sign;
    logic [ADC_BITS-1:0] in_mag;

    logic                s1_valid, s1_sign;
    logic [ADC_BITS-1:0] s1_mag;
    logic [31:0]         s1_gain, s1_offset;

    logic                s2_valid, s2_sign, s2_zero;
    logic [4:0]          s2_pos;
    logic [ADC_BITS-1:0] s2_mag;
    logic [31:0]         s2_gain, s2_offset;

    logic [4:0]          lod_pos;
    logic                lod_zero;
    logic [23:0]         mag_ext;
    logic [23:0]         mant_full;
    logic [7:0]          exp_field;
    logic [31:0]         packed_val;

    logic                out_valid;
    logic [31:0]         out_val, out_gain, out_offset;
    logic [31:0]         cnt_q;

    // Single global enable: the whole pipeline freezes while the output is stalled.
    assign en                = ~out_valid | m_axis_tready;
    assign s_raw_axis_tready = en;

    // A coefficient arriving in the acceptance cycle applies to that very sample.
    assign gain_snap   = i_gain_s_axis_tvalid   ? i_gain_s_axis_tdata   : gain_shadow;
    assign offset_snap = i_offset_s_axis_tvalid ? i_offset_s_axis_tdata : offset_shadow;

`ifdef ADC_SIGNED_CODE_EN
    assign in_sign = s_raw_axis_tdata[ADC_BITS-1];
    assign in_mag  = in_sign ? (-s_raw_axis_tdata) : s_raw_axis_tdata;
`else
    assign in_sign = 1'b0;
    assign in_mag  = s_raw_axis_tdata;
`endif

    always_comb begin
        lod_pos = '0;
        for (int i = 0; i < ADC_BITS; i++) begin
            if (s1_mag[i]) lod_pos = 5'(i);
        end
    end
    assign lod_zero = (s1_mag == '0);

    // The leading one lands on bit 23 and is dropped as the hidden bit.
    assign mag_ext    = 24'(s2_mag);
    assign mant_full  = mag_ext << (5'd23 - s2_pos);
    assign exp_field  = 8'd127 + {3'b000, s2_pos};
    assign packed_val = s2_zero ? 32'h0000_0000 : {s2_sign, exp_field, mant_full[22:0]};

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            gain_shadow   <= GAIN_RST;
            offset_shadow <= OFFSET_RST;
        end else begin
            if (i_gain_s_axis_tvalid)   gain_shadow   <= i_gain_s_axis_tdata;
            if (i_offset_s_axis_tvalid) offset_shadow <= i_offset_s_axis_tdata;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_mag     <= '0;
            s1_gain    <= GAIN_RST;
            s1_offset  <= OFFSET_RST;
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_zero    <= 1'b1;
            s2_pos     <= '0;
            s2_mag     <= '0;
            s2_gain    <= GAIN_RST;
            s2_offset  <= OFFSET_RST;
            out_valid  <= 1'b0;
            out_val    <= 32'h0000_0000;
            out_gain   <= GAIN_RST;
            out_offset <= OFFSET_RST;
        end else if (en) begin
            s1_valid   <= s_raw_axis_tvalid;
            s1_sign    <= in_sign;
            s1_mag     <= in_mag;
            s1_gain    <= gain_snap;
            s1_offset  <= offset_snap;
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_zero    <= lod_zero;
            s2_pos     <= lod_pos;
            s2_mag     <= s1_mag;
            s2_gain    <= s1_gain;
            s2_offset  <= s1_offset;
            out_valid  <= s2_valid;
            out_val    <= packed_val;
            out_gain   <= s2_gain;
            out_offset <= s2_offset;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            cnt_q <= 32'h0000_0000;
        end else if (out_valid && m_axis_tready) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign m_axis_tvalid       = out_valid;
    assign m_val_axis_tdata    = out_val;
    assign m_gain_axis_tdata   = out_gain;
    assign m_offset_axis_tdata = out_offset;
    assign o_sample_cnt        = cnt_q;

endmodule

// File: tb/tb_adc_code_to_float.sv
// Bench for adc_code_to_float: real-arithmetic reference model, expected queue scoreboard,
// directed conversion/alignment/reset/wrap scenarios and randomized backpressure.
module tb_adc_code_to_float;

  localparam int          ADC_BITS   = 24;
  localparam logic [31:0] GAIN_RST   = 32'h35a0_0000;
  localparam logic [31:0] OFFSET_RST = 32'hc120_0000;

  logic                clk;
  logic                aresetn;
  logic [ADC_BITS-1:0] s_raw_axis_tdata;
  logic                s_raw_axis_tvalid;
  logic                s_raw_axis_tready;
  logic [31:0]         i_gain_s_axis_tdata;
  logic                i_gain_s_axis_tvalid;
  logic [31:0]         i_offset_s_axis_tdata;
  logic                i_offset_s_axis_tvalid;
  logic [31:0]         m_val_axis_tdata;
  logic [31:0]         m_gain_axis_tdata;
  logic [31:0]         m_offset_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [31:0]         o_sample_cnt;

  adc_code_to_float #(
    .ADC_BITS  (ADC_BITS),
    .GAIN_RST  (GAIN_RST),
    .OFFSET_RST(OFFSET_RST)
  ) dut (
    .s00_axi_aclk          (clk),
    .s00_axi_aresetn       (aresetn),
    .s_raw_axis_tdata      (s_raw_axis_tdata),
    .s_raw_axis_tvalid     (s_raw_axis_tvalid),
    .s_raw_axis_tready     (s_raw_axis_tready),
    .i_gain_s_axis_tdata   (i_gain_s_axis_tdata),
    .i_gain_s_axis_tvalid  (i_gain_s_axis_tvalid),
    .i_offset_s_axis_tdata (i_offset_s_axis_tdata),
    .i_offset_s_axis_tvalid(i_offset_s_axis_tvalid),
    .m_val_axis_tdata      (m_val_axis_tdata),
    .m_gain_axis_tdata     (m_gain_axis_tdata),
    .m_offset_axis_tdata   (m_offset_axis_tdata),
    .m_axis_tvalid         (m_axis_tvalid),
    .m_axis_tready         (m_axis_tready),
    .o_sample_cnt          (o_sample_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Converts via real arithmetic and re-encodes the double as a single.
  function automatic logic [31:0] ref_float(input logic [ADC_BITS-1:0] code);
    int          v;
    real         r;
    logic [63:0] d;
    logic [10:0] e;
`ifdef ADC_SIGNED_CODE_EN
    v = int'($signed(code));
`else
    v = int'({8'h00, code});
`endif
    r = v;
    if (r == 0.0) return 32'h0000_0000;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] val_log[$];
  logic [31:0] gain_log[$];
  int          lat_log[$];
  logic [31:0] sh_gain = GAIN_RST;
  logic [31:0] sh_off  = OFFSET_RST;
  logic [31:0] exp_cnt = 32'h0;
  logic        hold_valid = 1'b0;
  logic [95:0] held;
  int          cyc = 0;

  always @(negedge clk) begin
    logic [95:0] e;
    logic [31:0] g, o;
    cyc++;
    if (!aresetn) begin
      exp_q.delete();
      acc_q.delete();
      sh_gain    = GAIN_RST;
      sh_off     = OFFSET_RST;
      exp_cnt    = 32'h0;
      hold_valid = 1'b0;
    end else begin
      check("tready_rule", {31'h0, s_raw_axis_tready}, {31'h0, (!m_axis_tvalid || m_axis_tready)});
      check("sample_cnt", o_sample_cnt, exp_cnt);
      if (hold_valid) begin
        check("hold_valid", {31'h0, m_axis_tvalid}, 32'h1);
        check("hold_val", m_val_axis_tdata, held[95:64]);
        check("hold_gain", m_gain_axis_tdata, held[63:32]);
        check("hold_offset", m_offset_axis_tdata, held[31:0]);
      end
      hold_valid = 1'b0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_output: got 0x%08h expected no output", m_val_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check("out_val", m_val_axis_tdata, e[95:64]);
            check("out_gain", m_gain_axis_tdata, e[63:32]);
            check("out_offset", m_offset_axis_tdata, e[31:0]);
            val_log.push_back(m_val_axis_tdata);
            gain_log.push_back(m_gain_axis_tdata);
            lat_log.push_back(cyc - acc_q.pop_front());
          end
          exp_cnt = exp_cnt + 32'd1;
        end else begin
          hold_valid = 1'b1;
          held = {m_val_axis_tdata, m_gain_axis_tdata, m_offset_axis_tdata};
        end
      end
      if (s_raw_axis_tvalid && s_raw_axis_tready) begin
        g = i_gain_s_axis_tvalid ? i_gain_s_axis_tdata : sh_gain;
        o = i_offset_s_axis_tvalid ? i_offset_s_axis_tdata : sh_off;
        exp_q.push_back({ref_float(s_raw_axis_tdata), g, o});
        acc_q.push_back(cyc);
        check("in_flight_le3", {31'h0, (exp_q.size() <= 3)}, 32'h1);
      end
      if (i_gain_s_axis_tvalid)   sh_gain = i_gain_s_axis_tdata;
      if (i_offset_s_axis_tvalid) sh_off  = i_offset_s_axis_tdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    s_raw_axis_tvalid      = 1'b0;
    i_gain_s_axis_tvalid   = 1'b0;
    i_offset_s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  task automatic send(input logic [ADC_BITS-1:0] code);
    int budget = 200;
    s_raw_axis_tdata  = code;
    s_raw_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_raw_axis_tready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL send_timeout: got no tready expected tready within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && b < 300) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (b >= 300) begin
      n_fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    val_log.delete();
    gain_log.delete();
    lat_log.delete();
  endtask

  task automatic random_run(input int n);
    bit src_done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          case ($urandom_range(0, 5))
            0:       send('0);
            1:       send({ADC_BITS{1'b1}});
            2:       send({1'b1, {(ADC_BITS-1){1'b0}}});
            default: send(ADC_BITS'($urandom));
          endcase
        end
        s_raw_axis_tvalid = 1'b0;
        src_done = 1'b1;
      end
      begin
        while (!src_done) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat (5) begin
              @(posedge clk);
              #1 m_axis_tready = 1'b0;
            end
          end else begin
            @(posedge clk);
            #1 m_axis_tready = 1'($urandom_range(0, 1));
          end
        end
        m_axis_tready = 1'b1;
      end
      begin
        while (!src_done) begin
          @(posedge clk);
          #1;
          i_gain_s_axis_tvalid   = ($urandom_range(0, 5) == 0);
          i_gain_s_axis_tdata    = $urandom;
          i_offset_s_axis_tvalid = ($urandom_range(0, 5) == 0);
          i_offset_s_axis_tdata  = $urandom;
        end
        i_gain_s_axis_tvalid   = 1'b0;
        i_offset_s_axis_tvalid = 1'b0;
      end
    join
    drain();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [ADC_BITS-1:0] codes[$];
    logic [31:0]         exps[$];

    s_raw_axis_tdata      = '0;
    i_gain_s_axis_tdata   = '0;
    i_offset_s_axis_tdata = '0;
    m_axis_tready         = 1'b1;

    // Pin the reference model against hand-computed encodings.
`ifdef ADC_SIGNED_CODE_EN
    check("model_min", ref_float(24'h800000), 32'hCB00_0000);
    check("model_m1", ref_float(24'hFFFFFF), 32'hBF80_0000);
    check("model_2", ref_float(24'h000002), 32'h4000_0000);
    codes = '{24'h800000, 24'hFFFFFF, 24'h000002};
    exps  = '{32'hCB00_0000, 32'hBF80_0000, 32'h4000_0000};
`else
    check("model_1", ref_float(24'h000001), 32'h3F80_0000);
    check("model_mid", ref_float(24'h800000), 32'h4B00_0000);
    check("model_max", ref_float(24'hFFFFFF), 32'h4B7F_FFFF);
    codes = '{24'h000000, 24'h000001, 24'h800000, 24'hFFFFFF};
    exps  = '{32'h0000_0000, 32'h3F80_0000, 32'h4B00_0000, 32'h4B7F_FFFF};
`endif
    check("model_0", ref_float(24'h000000), 32'h0000_0000);

    // Reset values.
    aresetn = 1'b0;
    s_raw_axis_tvalid      = 1'b0;
    i_gain_s_axis_tvalid   = 1'b0;
    i_offset_s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("rst_val", m_val_axis_tdata, 32'h0);
    check("rst_gain", m_gain_axis_tdata, GAIN_RST);
    check("rst_offset", m_offset_axis_tdata, OFFSET_RST);
    check("rst_cnt", o_sample_cnt, 32'h0);
    aresetn = 1'b1;
    #1;
    check("rst_tready", {31'h0, s_raw_axis_tready}, 32'h1);

    // Directed back-to-back conversions with tready held high.
    clear_logs();
    foreach (codes[k]) send(codes[k]);
    s_raw_axis_tvalid = 1'b0;
    drain();
    check("dir_count", val_log.size(), codes.size());
    foreach (exps[k]) begin
      if (k < val_log.size()) begin
        check($sformatf("dir_val%0d", k), val_log[k], exps[k]);
        check($sformatf("dir_lat%0d", k), lat_log[k], 32'd3);
      end
    end

    // Coefficient alignment: B one cycle before A, gain update alongside A.
    do_reset();
    clear_logs();
    @(posedge clk);
    #1;
    s_raw_axis_tdata = 24'h000100;
    s_raw_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_raw_axis_tdata       = 24'h000200;
    i_gain_s_axis_tdata    = 32'h39a0_00a0;
    i_gain_s_axis_tvalid   = 1'b1;
    @(posedge clk);
    #1;
    s_raw_axis_tvalid    = 1'b0;
    i_gain_s_axis_tvalid = 1'b0;
    drain();
    check("align_count", gain_log.size(), 32'd2);
    if (gain_log.size() == 2) begin
      check("align_gain_b", gain_log[0], 32'h35a0_0000);
      check("align_gain_a", gain_log[1], 32'h39a0_00a0);
    end

    // Backpressure: 10 samples with random stalls and coefficient traffic.
    do_reset();
    clear_logs();
    random_run(10);
    check("bp_count", val_log.size(), 32'd10);
    check("bp_cnt", o_sample_cnt, 32'd10);

    // Longer random stream.
    random_run(40);

    // Reset with three samples in flight and changed coefficients.
    m_axis_tready = 1'b0;
    send(24'h000011);
    send(24'h000022);
    send(24'h000033);
    s_raw_axis_tvalid      = 1'b0;
    i_gain_s_axis_tdata    = 32'h1234_5678;
    i_gain_s_axis_tvalid   = 1'b1;
    i_offset_s_axis_tdata  = 32'h8765_4321;
    i_offset_s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    i_gain_s_axis_tvalid   = 1'b0;
    i_offset_s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("mid_rst_gain", m_gain_axis_tdata, 32'h35a0_0000);
    check("mid_rst_offset", m_offset_axis_tdata, 32'hc120_0000);
    check("mid_rst_cnt", o_sample_cnt, 32'h0);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    clear_logs();
    send(24'h000044);
    s_raw_axis_tvalid = 1'b0;
    drain();
    check("post_rst_gain", (gain_log.size() > 0) ? gain_log[0] : 32'hDEAD_BEEF, GAIN_RST);

    // Counter wrap.
    @(posedge clk);
    #1;
    force dut.cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    @(negedge clk);
    check("wrap_pre", o_sample_cnt, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    send(24'h000055);
    s_raw_axis_tvalid = 1'b0;
    drain();
    check("wrap_post", o_sample_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
